cam_alloc: RTL and testbench
============================

Name: cam_alloc

Overview:
- Write-slot allocator for the CAM; sits directly upstream of the CAM address decoder.
- Tracks which CAM entries hold valid keys and finds the lowest free entry.
- Grants allocation requests with a registered write address and write strobe. The address feeds the decoder, which produces the one-hot row select.
- Accepts release of individual entries and a global flush.

Parameters:
- ADDR_WIDTH, 5, index bits for one CAM entry; address ports are ADDR_WIDTH+1 bits wide, matching the decoder input.
- CAM_DEPTH, 32, number of CAM entries; must be <= 2**ADDR_WIDTH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- alloc_req_i  input  1  request one free entry this cycle.
- alloc_gnt_o  output  1  combinational grant: alloc_req_i & ~full_o & ~flush_i.
- wr_en_o  output  1  registered one-cycle write strobe to the CAM.
- wr_addr_o  output  ADDR_WIDTH+1  registered index of the granted entry; drives the decoder input.
- free_req_i  input  1  release the entry at free_addr_i.
- free_addr_i  input  ADDR_WIDTH+1  index to release.
- flush_i  input  1  invalidate all entries.
- valid_o  output  CAM_DEPTH  registered per-entry valid bitmap.
- count_o  output  ADDR_WIDTH+1  number of valid entries, 0..CAM_DEPTH.
- full_o  output  1  count_o == CAM_DEPTH.
- empty_o  output  1  count_o == 0.
- err_o  output  1  sticky error flag; cleared only by rst or flush_i.

Behaviour:
- Reset values (asynchronous on rst high):
  - valid_o = 0, count_o = 0, wr_en_o = 0, wr_addr_o = 0, err_o = 0.
  - empty_o = 1, full_o = 0.
- Free search:
  - next_free is the lowest index i with valid_o[i] == 0, found by a combinational priority scan of the registered bitmap.
  - The scan is undefined when full; it is never used when full.
- Allocation, latency 1 cycle:
  - When alloc_gnt_o = 1 at edge N, the following all take effect from edge N: valid_o[next_free] = 1, wr_addr_o = next_free, wr_en_o = 1 for exactly one cycle, count_o increments.
  - wr_addr_o holds its last value when no grant occurs; wr_en_o = 0.
  - Back-to-back requests are granted every cycle while not full. Consecutive grants return ascending free indices.
- Full:
  - While full_o = 1, alloc_req_i gets alloc_gnt_o = 0 and no state changes. The requester holds its request and stalls.
  - There is no error for a request while full.
- Free:
  - A valid free clears valid_o[free_addr_i] at the next edge and decrements count_o.
  - A released entry becomes visible to the free search one cycle later. It is never reallocated in the same cycle it is freed.
- Free errors, each sets err_o = 1 with no bitmap or count change:
  - free_addr_i >= CAM_DEPTH;
  - free of an entry whose valid_o bit is already 0.
- Simultaneous alloc and free, neither flush:
  - Both apply in the same cycle.
  - The allocated entry is next_free from the pre-edge bitmap.
  - count_o is unchanged (+1 -1).
  - The freed index cannot equal next_free, because next_free is invalid; that case is the free-of-invalid error and only the alloc applies.
- Flush:
  - flush_i has the highest priority: valid_o = 0, count_o = 0, err_o = 0, wr_en_o = 0 at the next edge.
  - alloc_gnt_o = 0 and any free in the same cycle is ignored.
  - wr_addr_o holds its value.
- Flag timing: full_o and empty_o are derived from registered count_o and are therefore valid in the same cycle as count_o.
- Invariant: count_o always equals popcount(valid_o); the bench checks this every cycle.
- Reset mid-operation: asserting rst during a wr_en_o pulse drops wr_en_o immediately (asynchronous); all state returns to the reset values.

Test Plan:
- Reset, then alloc_req_i high for 3 cycles -> wr_en_o pulses on 3 consecutive cycles with wr_addr_o = 0, 1, 2; count_o = 3; valid_o = 0x00000007.
- Fill all 32 entries, then hold alloc_req_i -> full_o = 1, alloc_gnt_o = 0, wr_en_o stays 0, count_o = 32. Free index 7, then request -> wr_addr_o = 7, full_o re-asserts.
- With entries 0..4 valid, free 2 and alloc in the same cycle -> wr_addr_o = 5; valid_o = 0x0000003B; count_o stays 5. A following alloc -> wr_addr_o = 2.
- Free index 10 while it is invalid -> err_o = 1, count_o unchanged. Free index 40 (>= CAM_DEPTH) -> err_o remains 1. Flush -> err_o = 0, valid_o = 0, empty_o = 1.
- Flush asserted together with alloc_req_i and free_req_i -> alloc_gnt_o = 0, no wr_en_o, count_o = 0 next cycle.
- Assert rst asynchronously mid-burst while wr_en_o = 1 -> wr_en_o, count_o and valid_o go to 0 before the next clock edge. After release, the first alloc -> wr_addr_o = 0.

Source files
------------

// File: rtl/cam_alloc_if.sv
// Handshake and status bundle between a CAM write requester and the slot allocator.
// The master drives the requests; the slave (cam_alloc) drives the grant, write and status signals.
interface cam_alloc_if #(
   parameter int ADDR_WIDTH = 5,
   parameter int CAM_DEPTH  = 32
);
   logic                  alloc_req_i;
   logic                  alloc_gnt_o;
   logic                  wr_en_o;
   logic [ADDR_WIDTH:0]   wr_addr_o;
   logic                  free_req_i;
   logic [ADDR_WIDTH:0]   free_addr_i;
   logic                  flush_i;
   logic [CAM_DEPTH-1:0]  valid_o;
   logic [ADDR_WIDTH:0]   count_o;
   logic                  full_o;
   logic                  empty_o;
   logic                  err_o;

   modport master (
      output alloc_req_i, free_req_i, free_addr_i, flush_i,
      input  alloc_gnt_o, wr_en_o, wr_addr_o, valid_o, count_o, full_o, empty_o, err_o
   );

   modport slave (
      input  alloc_req_i, free_req_i, free_addr_i, flush_i,
      output alloc_gnt_o, wr_en_o, wr_addr_o, valid_o, count_o, full_o, empty_o, err_o
   );
endinterface

// File: rtl/cam_alloc.sv
// CAM write-slot allocator: tracks valid entries, grants the lowest free entry,
// and handles per-entry release, global flush and a sticky error flag for bad releases.
module cam_alloc #(
   parameter int ADDR_WIDTH = 5,
   parameter int CAM_DEPTH  = 32
) (
   input logic        clk,
   input logic        rst,
   cam_alloc_if.slave bus
);
   localparam int AW = ADDR_WIDTH + 1;

   logic [CAM_DEPTH-1:0]  valid_q;
   logic [CAM_DEPTH-1:0]  valid_nxt;
   logic [AW-1:0]         count_q;
   logic [AW-1:0]         wr_addr_q;
   logic                  wr_en_q;
   logic                  err_q;

   logic [AW-1:0]         next_free;
   logic [ADDR_WIDTH-1:0] free_idx;
   logic                  full;
   logic                  gnt;
   logic                  free_in_range;
   logic                  free_ok;
   logic                  free_err;

   // Lowest clear bit wins; result is don't-care when full since no grant can happen.
   always_comb begin
      next_free = '0;
      for (int i = CAM_DEPTH - 1; i >= 0; i--) begin
         if (!valid_q[i]) next_free = AW'(i);
      end
   end

   assign full          = (count_q == AW'(CAM_DEPTH));
   assign gnt           = bus.alloc_req_i & ~full & ~bus.flush_i;
   assign free_idx      = bus.free_addr_i[ADDR_WIDTH-1:0];
   assign free_in_range = (bus.free_addr_i < AW'(CAM_DEPTH));
   assign free_ok       = bus.free_req_i & ~bus.flush_i & free_in_range & valid_q[free_idx];
   assign free_err      = bus.free_req_i & ~bus.flush_i & ~(free_in_range & valid_q[free_idx]);

   // A free of next_free is impossible here: that bit is clear, so free_ok is already low.
   always_comb begin
      valid_nxt = valid_q;
      if (free_ok) valid_nxt[free_idx] = 1'b0;
      if (gnt)     valid_nxt[next_free[ADDR_WIDTH-1:0]] = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q   <= '0;
         count_q   <= '0;
         wr_addr_q <= '0;
         wr_en_q   <= 1'b0;
         err_q     <= 1'b0;
      end else if (bus.flush_i) begin
         valid_q <= '0;
         count_q <= '0;
         wr_en_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         valid_q <= valid_nxt;
         wr_en_q <= gnt;
         if (gnt) wr_addr_q <= next_free;
         if (free_err) err_q <= 1'b1;
         case ({gnt, free_ok})
            2'b10:   count_q <= count_q + AW'(1);
            2'b01:   count_q <= count_q - AW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   assign bus.alloc_gnt_o = gnt;
   assign bus.wr_en_o     = wr_en_q;
   assign bus.wr_addr_o   = wr_addr_q;
   assign bus.valid_o     = valid_q;
   assign bus.count_o     = count_q;
   assign bus.full_o      = full;
   assign bus.empty_o     = (count_q == '0);
   assign bus.err_o       = err_q;
endmodule

// File: tb/tb_cam_alloc.sv
// Self-checking bench for cam_alloc: directed scenarios followed by random traffic,
// all compared against an array-based reference model of the allocator.
module tb_cam_alloc;
   localparam int ADDR_WIDTH = 5;
   localparam int CAM_DEPTH  = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk  = 0;
   int   n_pass = 0;

   cam_alloc_if #(.ADDR_WIDTH(ADDR_WIDTH), .CAM_DEPTH(CAM_DEPTH)) bus ();

   cam_alloc #(.ADDR_WIDTH(ADDR_WIDTH), .CAM_DEPTH(CAM_DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Reference model state: a plain array of occupied flags.
   bit m_valid [CAM_DEPTH];
   bit m_err;
   bit m_wr_en;
   int m_wr_addr;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
   endtask

   function automatic int m_count();
      int c = 0;
      for (int i = 0; i < CAM_DEPTH; i++) c += int'(m_valid[i]);
      return c;
   endfunction

   function automatic logic [63:0] m_bitmap();
      logic [63:0] v = '0;
      for (int i = 0; i < CAM_DEPTH; i++) v[i] = m_valid[i];
      return v;
   endfunction

   function automatic int m_first_free();
      for (int i = 0; i < CAM_DEPTH; i++) if (!m_valid[i]) return i;
      return -1;
   endfunction

   task automatic m_reset();
      for (int i = 0; i < CAM_DEPTH; i++) m_valid[i] = 1'b0;
      m_err = 1'b0;
      m_wr_en = 1'b0;
      m_wr_addr = 0;
   endtask

   task automatic check_state(input string tag);
      check({tag, ".wr_en"},   64'(bus.wr_en_o),   64'(m_wr_en));
      check({tag, ".wr_addr"}, 64'(bus.wr_addr_o), 64'(m_wr_addr));
      check({tag, ".valid"},   64'(bus.valid_o),   m_bitmap());
      check({tag, ".count"},   64'(bus.count_o),   64'(m_count()));
      check({tag, ".full"},    64'(bus.full_o),    64'(m_count() == CAM_DEPTH));
      check({tag, ".empty"},   64'(bus.empty_o),   64'(m_count() == 0));
      check({tag, ".err"},     64'(bus.err_o),     64'(m_err));
      check({tag, ".popcnt"},  64'(bus.count_o),   64'($countones(bus.valid_o)));
   endtask

   // Drives one cycle of stimulus starting at a falling edge and ends at the next falling edge.
   task automatic cycle(input bit a, input bit f, input int fa, input bit fl, input string tag);
      bit exp_gnt;
      int nf;
      bit fv;
      bus.alloc_req_i = a;
      bus.free_req_i  = f;
      bus.free_addr_i = 6'(fa);
      bus.flush_i     = fl;
      #1;
      exp_gnt = a && (m_count() != CAM_DEPTH) && !fl;
      check({tag, ".gnt"}, 64'(bus.alloc_gnt_o), 64'(exp_gnt));
      @(posedge clk);
      if (fl) begin
         for (int i = 0; i < CAM_DEPTH; i++) m_valid[i] = 1'b0;
         m_err = 1'b0;
         m_wr_en = 1'b0;
      end else begin
         nf = m_first_free();
         fv = f && (fa < CAM_DEPTH) && m_valid[fa % CAM_DEPTH];
         if (f && !fv) m_err = 1'b1;
         if (fv) m_valid[fa] = 1'b0;
         if (exp_gnt) begin
            m_valid[nf] = 1'b1;
            m_wr_addr = nf;
         end
         m_wr_en = exp_gnt;
      end
      #1;
      check_state(tag);
      @(negedge clk);
   endtask

   initial begin
      int fa;
      bus.alloc_req_i = 1'b0;
      bus.free_req_i  = 1'b0;
      bus.free_addr_i = '0;
      bus.flush_i     = 1'b0;
      m_reset();
      repeat (2) @(posedge clk);
      #1;
      check_state("reset");
      @(negedge clk);
      rst = 1'b0;

      // Three back-to-back allocations return 0,1,2.
      for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, "burst3");
      check("burst3.bitmap", 64'(bus.valid_o), 64'h7);
      check("burst3.addr",   64'(bus.wr_addr_o), 64'd2);

      // Fill, then stall on full.
      for (int i = 3; i < CAM_DEPTH; i++) cycle(1, 0, 0, 0, "fill");
      for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, "stall");
      check("stall.full", 64'(bus.full_o), 64'd1);
      cycle(0, 1, 7, 0, "free7");
      cycle(1, 0, 0, 0, "realloc7");
      check("realloc7.addr", 64'(bus.wr_addr_o), 64'd7);
      check("realloc7.full", 64'(bus.full_o), 64'd1);

      // Simultaneous alloc and free.
      cycle(0, 0, 0, 1, "flush1");
      for (int i = 0; i < 5; i++) cycle(1, 0, 0, 0, "fill5");
      cycle(1, 1, 2, 0, "allocfree");
      check("allocfree.addr",  64'(bus.wr_addr_o), 64'd5);
      check("allocfree.map",   64'(bus.valid_o),   64'h3B);
      check("allocfree.count", 64'(bus.count_o),   64'd5);
      cycle(1, 0, 0, 0, "refill2");
      check("refill2.addr", 64'(bus.wr_addr_o), 64'd2);

      // Free errors and flush clearing the flag.
      cycle(0, 1, 10, 0, "freeinv");
      check("freeinv.err", 64'(bus.err_o), 64'd1);
      cycle(0, 1, 40, 0, "freerange");
      cycle(0, 0, 0, 1, "flusherr");
      check("flusherr.err",   64'(bus.err_o),   64'd0);
      check("flusherr.empty", 64'(bus.empty_o), 64'd1);

      // Flush beats alloc and free in the same cycle.
      cycle(1, 0, 0, 0, "pre");
      cycle(1, 0, 0, 0, "pre");
      cycle(1, 1, 0, 1, "flushall");
      check("flushall.count", 64'(bus.count_o), 64'd0);

      // Asynchronous reset while a write strobe is active.
      cycle(1, 0, 0, 0, "prerst");
      cycle(1, 0, 0, 0, "prerst");
      check("prerst.wr_en", 64'(bus.wr_en_o), 64'd1);
      #2;
      rst = 1'b1;
      #1;
      m_reset();
      check_state("asyncrst");
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      cycle(1, 0, 0, 0, "postrst");
      check("postrst.addr", 64'(bus.wr_addr_o), 64'd0);

      // Random traffic.
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 7) != 0) fa = $urandom_range(0, CAM_DEPTH - 1);
         else fa = $urandom_range(CAM_DEPTH, 63);
         cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 9) < 4), fa,
               ($urandom_range(0, 99) == 0), "rand");
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got no finish, expected finish within time limit");
      $fatal(1);
   end
endmodule
